// File: rtl/tm_pkg.sv
// Shared definitions for the time manager: FSM state encoding and the
// all-ones limit helper used for DT_MAX and the emu_time ceiling.
package tm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } tm_state_e;

    // Widths of 64 or more saturate to all ones instead of shifting out.
    function automatic logic [63:0] dt_max(input int width);
        logic [63:0] one;
        one = 64'd1;
        if (width >= 64) begin
            return '1;
        end
        return (one << width) - 64'd1;
    endfunction

endpackage

// File: rtl/tm_min_tree.sv
// Combinational minimum search over the enabled channels, plus a mask of
// every enabled channel whose request equals that minimum.
module tm_min_tree
    import tm_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int DT_WIDTH = 25
) (
    input  logic [N_CH*DT_WIDTH-1:0] dt_req,
    input  logic [N_CH-1:0]          ch_en,
    output logic [DT_WIDTH-1:0]      min_dt,
    output logic [N_CH-1:0]          eq_mask
);

    localparam int LEVELS = (N_CH > 1) ? $clog2(N_CH) : 0;
    localparam int LEAVES = 1 << LEVELS;
    localparam logic [DT_WIDTH-1:0] DT_MAX = DT_WIDTH'(dt_max(DT_WIDTH));

    // Heap-ordered binary tree: leaves at [LEAVES +: LEAVES], root at 1.
    // Disabled and padding leaves sit at DT_MAX so they never win.
    logic [DT_WIDTH-1:0] node [1:2*LEAVES-1];

    always_comb begin
        for (int n = 1; n < 2*LEAVES; n++) begin
            node[n] = DT_MAX;
        end
        for (int i = 0; i < N_CH; i++) begin
            if (ch_en[i]) begin
                node[LEAVES+i] = dt_req[i*DT_WIDTH +: DT_WIDTH];
            end
        end
        for (int n = LEAVES - 1; n >= 1; n--) begin
            node[n] = (node[2*n] < node[2*n+1]) ? node[2*n] : node[2*n+1];
        end
    end

    assign min_dt = node[1];

    always_comb begin
        eq_mask = '0;
        for (int i = 0; i < N_CH; i++) begin
            eq_mask[i] = ch_en[i] && (dt_req[i*DT_WIDTH +: DT_WIDTH] == min_dt);
        end
    end

endmodule

// File: rtl/time_manager_nch.sv
// Global time-step arbiter with stall, zero-step watchdog and fault latch.
// Define TM_EMU_TIME_EN to add the saturating emu_time accumulator.
module time_manager_nch
    import tm_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int DT_WIDTH    = 25,
    parameter int TIME_WIDTH  = 64,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                     emu_clk,
    input  logic                     emu_rst_n,
    input  logic [N_CH*DT_WIDTH-1:0] dt_req,
    input  logic [N_CH-1:0]          ch_en,
    input  logic                     emu_stall,
    input  logic                     fault_clr,
    output logic [DT_WIDTH-1:0]      emu_dt,
    output logic [N_CH-1:0]          dt_grant,
    output logic                     fault,
    output logic [TIME_WIDTH-1:0]    emu_time
);

    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_CYCLES);

    tm_state_e           state;
    logic [WDOG_W-1:0]   wdog_cnt;
    logic [WDOG_W-1:0]   wdog_inc;
    logic [DT_WIDTH-1:0] min_dt;
    logic [N_CH-1:0]     eq_mask;
    logic                issuing;
    logic                zero_issue;

    tm_min_tree #(
        .N_CH     (N_CH),
        .DT_WIDTH (DT_WIDTH)
    ) u_min_tree (
        .dt_req  (dt_req),
        .ch_en   (ch_en),
        .min_dt  (min_dt),
        .eq_mask (eq_mask)
    );

    // HOLD resumes issuing in the same edge stall drops, so emu_dt is zero
    // for exactly as many cycles as emu_stall was high.
    assign issuing    = ((state == ST_RUN) || (state == ST_HOLD)) && !emu_stall;
    assign zero_issue = (|ch_en) && (min_dt == '0);
    assign wdog_inc   = (wdog_cnt == WDOG_LIMIT) ? wdog_cnt : wdog_cnt + 1'b1;

    always_ff @(posedge emu_clk) begin
        if (!emu_rst_n) begin
            state    <= ST_IDLE;
            emu_dt   <= '0;
            dt_grant <= '0;
            fault    <= 1'b0;
            wdog_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_RUN;
                    emu_dt   <= '0;
                    dt_grant <= '0;
                end
                ST_RUN, ST_HOLD: begin
                    if (!issuing) begin
                        state    <= ST_HOLD;
                        emu_dt   <= '0;
                        dt_grant <= '0;
                    end else if (zero_issue && (wdog_inc == WDOG_LIMIT)) begin
                        state    <= ST_FAULT;
                        fault    <= 1'b1;
                        wdog_cnt <= wdog_inc;
                        emu_dt   <= '0;
                        dt_grant <= '0;
                    end else begin
                        state    <= ST_RUN;
                        emu_dt   <= min_dt;
                        dt_grant <= eq_mask;
                        wdog_cnt <= zero_issue ? wdog_inc : '0;
                    end
                end
                ST_FAULT: begin
                    emu_dt   <= '0;
                    dt_grant <= '0;
                    if (fault_clr) begin
                        state    <= ST_RUN;
                        fault    <= 1'b0;
                        wdog_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    emu_dt   <= '0;
                    dt_grant <= '0;
                end
            endcase
        end
    end

`ifdef TM_EMU_TIME_EN
    localparam int SUM_W = ((TIME_WIDTH > DT_WIDTH) ? TIME_WIDTH : DT_WIDTH) + 1;
    localparam logic [TIME_WIDTH-1:0] TIME_MAX = TIME_WIDTH'(dt_max(TIME_WIDTH));

    logic [DT_WIDTH-1:0] step;
    logic [SUM_W-1:0]    time_sum;

    // Accumulate the step being registered this edge so emu_time always
    // includes the emu_dt currently on the output.
    assign step     = issuing ? min_dt : '0;
    assign time_sum = SUM_W'(emu_time) + SUM_W'(step);

    always_ff @(posedge emu_clk) begin
        if (!emu_rst_n) begin
            emu_time <= '0;
        end else if (time_sum > SUM_W'(TIME_MAX)) begin
            emu_time <= TIME_MAX;
        end else begin
            emu_time <= time_sum[TIME_WIDTH-1:0];
        end
    end
`else
    assign emu_time = '0;
`endif

endmodule

// File: tb/tb_time_manager_nch.sv
// Bench for time_manager_nch: directed scenarios plus random traffic checked
// against a queue-based model; a second instance uses an 8-bit emu_time.
module tb_time_manager_nch;

    localparam int N_CH     = 4;
    localparam int DT_WIDTH = 25;
    localparam int WDOG     = 8;
    localparam logic [63:0] DT_MAX = (64'd1 << DT_WIDTH) - 64'd1;
`ifdef TM_EMU_TIME_EN
    localparam bit TIME_ON = 1'b1;
`else
    localparam bit TIME_ON = 1'b0;
`endif

    logic                     emu_clk = 1'b0;
    logic                     emu_rst_n;
    logic [N_CH*DT_WIDTH-1:0] dt_req;
    logic [N_CH-1:0]          ch_en;
    logic                     emu_stall;
    logic                     fault_clr;
    logic [DT_WIDTH-1:0]      emu_dt, emu_dt_b;
    logic [N_CH-1:0]          dt_grant, dt_grant_b;
    logic                     fault, fault_b;
    logic [63:0]              emu_time;
    logic [7:0]               emu_time_b;

    int assertCount = 0;
    int failCount   = 0;

    int unsigned cur_req [N_CH];

    bit          m_started, m_faulted;
    int          m_zero_run;
    logic [63:0] m_dt, m_time, m_time8;
    logic [3:0]  m_grant;
    bit          m_fault;

    time_manager_nch #(
        .N_CH(N_CH), .DT_WIDTH(DT_WIDTH), .TIME_WIDTH(64), .WDOG_CYCLES(WDOG)
    ) dut (
        .emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .dt_req(dt_req), .ch_en(ch_en),
        .emu_stall(emu_stall), .fault_clr(fault_clr), .emu_dt(emu_dt),
        .dt_grant(dt_grant), .fault(fault), .emu_time(emu_time)
    );

    time_manager_nch #(
        .N_CH(N_CH), .DT_WIDTH(DT_WIDTH), .TIME_WIDTH(8), .WDOG_CYCLES(WDOG)
    ) dut_b (
        .emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .dt_req(dt_req), .ch_en(ch_en),
        .emu_stall(emu_stall), .fault_clr(fault_clr), .emu_dt(emu_dt_b),
        .dt_grant(dt_grant_b), .fault(fault_b), .emu_time(emu_time_b)
    );

    always #5 emu_clk = ~emu_clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock of reference behaviour: outputs after the edge at which the
    // given inputs were sampled.
    task automatic modelStep(input bit rst_n, input logic [3:0] en,
                             input bit stall, input bit clr);
        int unsigned live [$];
        int unsigned lo [$];
        logic [64:0] wide;
        m_dt    = 64'd0;
        m_grant = 4'd0;
        if (!rst_n) begin
            m_started  = 1'b0;
            m_faulted  = 1'b0;
            m_zero_run = 0;
            m_time     = 64'd0;
            m_time8    = 64'd0;
        end else begin
            if (!m_started) begin
                m_started = 1'b1;
            end else if (m_faulted) begin
                if (clr) begin
                    m_faulted  = 1'b0;
                    m_zero_run = 0;
                end
            end else if (!stall) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (en[i]) live.push_back(cur_req[i]);
                end
                if (live.size() == 0) begin
                    m_dt       = DT_MAX;
                    m_zero_run = 0;
                end else begin
                    lo   = live.min();
                    m_dt = 64'(lo[0]);
                    for (int i = 0; i < N_CH; i++) begin
                        m_grant[i] = en[i] && (64'(cur_req[i]) == m_dt);
                    end
                    if (m_dt == 64'd0) begin
                        m_zero_run++;
                        if (m_zero_run >= WDOG) begin
                            m_faulted = 1'b1;
                            m_grant   = 4'd0;
                        end
                    end else begin
                        m_zero_run = 0;
                    end
                end
            end
            wide    = {1'b0, m_time} + {1'b0, m_dt};
            m_time  = wide[64] ? 64'hFFFF_FFFF_FFFF_FFFF : wide[63:0];
            m_time8 = (m_time8 + m_dt > 64'd255) ? 64'd255 : m_time8 + m_dt;
        end
        m_fault = m_faulted;
    endtask

    task automatic applyStimulus(input string tag, input bit rst_n, input logic [3:0] en,
                                 input bit stall, input bit clr);
        for (int i = 0; i < N_CH; i++) begin
            dt_req[i*DT_WIDTH +: DT_WIDTH] = DT_WIDTH'(cur_req[i]);
        end
        emu_rst_n = rst_n;
        ch_en     = en;
        emu_stall = stall;
        fault_clr = clr;
        @(posedge emu_clk);
        modelStep(rst_n, en, stall, clr);
        #1;
        checkOutput({tag, "_dt"},     64'(emu_dt),     m_dt);
        checkOutput({tag, "_grant"},  64'(dt_grant),   64'(m_grant));
        checkOutput({tag, "_fault"},  64'(fault),      64'(m_fault));
        checkOutput({tag, "_time"},   emu_time,        TIME_ON ? m_time : 64'd0);
        checkOutput({tag, "_dt8"},    64'(emu_dt_b),   m_dt);
        checkOutput({tag, "_fault8"}, 64'(fault_b),    64'(m_fault));
        checkOutput({tag, "_time8"},  64'(emu_time_b), TIME_ON ? m_time8 : 64'd0);
    endtask

    task automatic setReq(input int unsigned r0, input int unsigned r1,
                          input int unsigned r2, input int unsigned r3);
        cur_req[0] = r0;
        cur_req[1] = r1;
        cur_req[2] = r2;
        cur_req[3] = r3;
    endtask

    task automatic resetAndStart();
        applyStimulus("rst", 1'b0, 4'hF, 1'b0, 1'b0);
        applyStimulus("start", 1'b1, 4'hF, 1'b0, 1'b0);
    endtask

    initial begin
        logic [63:0] held_time;
        logic [3:0]  r_en;
        setReq(40, 12, 12, 90);

        applyStimulus("rst0", 1'b0, 4'hF, 1'b0, 1'b0);
        applyStimulus("rst1", 1'b0, 4'hF, 1'b0, 1'b0);
        checkOutput("reset_dt", 64'(emu_dt), 64'd0);
        checkOutput("reset_fault", 64'(fault), 64'd0);
        applyStimulus("idle", 1'b1, 4'hF, 1'b0, 1'b0);
        checkOutput("idle_dt", 64'(emu_dt), 64'd0);

        applyStimulus("tie", 1'b1, 4'hF, 1'b0, 1'b0);
        checkOutput("tie_dt", 64'(emu_dt), 64'd12);
        checkOutput("tie_grant", 64'(dt_grant), 64'b0110);
        applyStimulus("mask", 1'b1, 4'b1001, 1'b0, 1'b0);
        checkOutput("mask_dt", 64'(emu_dt), 64'd40);
        checkOutput("mask_grant", 64'(dt_grant), 64'b0001);
        applyStimulus("none", 1'b1, 4'b0000, 1'b0, 1'b0);
        checkOutput("none_dt", 64'(emu_dt), DT_MAX);
        checkOutput("none_grant", 64'(dt_grant), 64'd0);

        held_time = TIME_ON ? m_time : 64'd0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus("stall", 1'b1, 4'hF, 1'b1, 1'b0);
            checkOutput("stall_dt", 64'(emu_dt), 64'd0);
            checkOutput("stall_grant", 64'(dt_grant), 64'd0);
            checkOutput("stall_time", emu_time, held_time);
        end
        applyStimulus("resume", 1'b1, 4'hF, 1'b0, 1'b0);
        checkOutput("resume_dt", 64'(emu_dt), 64'd12);

        // Watchdog: channel 0 alone requesting zero; fault_clr in RUN is ignored.
        resetAndStart();
        setReq(0, 50, 50, 50);
        for (int k = 1; k <= 7; k++) begin
            applyStimulus("wdog", 1'b1, 4'b0001, 1'b0, k == 3);
            checkOutput("wdog_nofault", 64'(fault), 64'd0);
        end
        applyStimulus("wdog8", 1'b1, 4'b0001, 1'b0, 1'b0);
        checkOutput("wdog_fault", 64'(fault), 64'd1);
        applyStimulus("fstall", 1'b1, 4'b0001, 1'b1, 1'b0);
        checkOutput("fault_stall", 64'(fault), 64'd1);
        applyStimulus("fclr", 1'b1, 4'b0001, 1'b0, 1'b1);
        checkOutput("fault_clr", 64'(fault), 64'd0);
        setReq(5, 50, 50, 50);
        applyStimulus("post_clr", 1'b1, 4'b0001, 1'b0, 1'b0);
        checkOutput("post_clr_dt", 64'(emu_dt), 64'd5);

        // Accumulation and saturation of the narrow instance.
        resetAndStart();
        setReq(7, 0, 0, 0);
        for (int k = 0; k < 10; k++) applyStimulus("acc", 1'b1, 4'b0001, 1'b0, 1'b0);
        checkOutput("acc_time", emu_time, TIME_ON ? 64'd70 : 64'd0);
        resetAndStart();
        setReq(200, 0, 0, 0);
        for (int k = 0; k < 2; k++) applyStimulus("sat", 1'b1, 4'b0001, 1'b0, 1'b0);
        checkOutput("sat_time8", 64'(emu_time_b), TIME_ON ? 64'd255 : 64'd0);

        // Reset taken from FAULT.
        setReq(0, 9, 9, 9);
        for (int k = 0; k < WDOG; k++) applyStimulus("refault", 1'b1, 4'hF, 1'b0, 1'b0);
        checkOutput("refault", 64'(fault), 64'd1);
        applyStimulus("midrst", 1'b0, 4'hF, 1'b0, 1'b0);
        checkOutput("midrst_fault", 64'(fault), 64'd0);
        checkOutput("midrst_time", emu_time, 64'd0);
        applyStimulus("mididle", 1'b1, 4'hF, 1'b0, 1'b0);
        checkOutput("mididle_dt", 64'(emu_dt), 64'd0);
        setReq(40, 12, 12, 90);
        applyStimulus("midrun", 1'b1, 4'hF, 1'b0, 1'b0);
        checkOutput("midrun_dt", 64'(emu_dt), 64'd12);

        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N_CH; i++) begin
                case ($urandom_range(0, 3))
                    0, 1:    cur_req[i] = 0;
                    2:       cur_req[i] = $urandom_range(1, 6);
                    default: cur_req[i] = $urandom & 32'h01FF_FFFF;
                endcase
            end
            r_en = 4'($urandom);
            applyStimulus("rand", $urandom_range(0, 63) != 0, r_en,
                          $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
